// File: rtl/text_line_fetch.sv
// Streams one 64-character row of the text-screen table to the glyph renderer.
// The ROM read latency is hidden by a 2-entry buffer with a bypass path to the output.
module text_line_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [4:0]  req_row,
  output logic        busy,
  output logic        done,
  output logic [10:0] rom_ad,
  output logic        rom_ce,
  output logic        rom_oce,
  input  logic [7:0]  rom_dout,
  output logic        ch_valid,
  input  logic        ch_ready,
  output logic [7:0]  ch_code,
  output logic [5:0]  ch_col,
  output logic        ch_last
);

  typedef enum logic {IDLE, FETCH} state_e;

  state_e      state_q;
  logic [4:0]  row_q;
  logic [6:0]  icol_q;
  logic [5:0]  ocol_q;
  logic [1:0]  cnt_q;
  logic        lnd_q;
  logic [7:0]  buf0_q, buf1_q;
  logic        rom_ce_q;
  logic [10:0] rom_ad_q;
  logic        done_q;

  logic        pop;
  logic        last_pop;
  logic [7:0]  head;
  logic [1:0]  cnt_d;
  logic [2:0]  occ_d;
  logic        issue_d;
  logic [7:0]  buf0_d, buf1_d;

  // Head of the stream is the oldest buffered byte, else the byte landing from the ROM now.
  always_comb begin
    ch_valid = (cnt_q != 2'd0) | lnd_q;
    pop      = ch_valid & ch_ready;
    last_pop = pop & (ocol_q == 6'd63);
    head     = (cnt_q != 2'd0) ? buf0_q : rom_dout;
    cnt_d    = cnt_q + {1'b0, lnd_q} - {1'b0, pop};
    // A read issued now lands two cycles later; only issue if a slot is guaranteed then.
    occ_d    = {1'b0, cnt_d} + {2'b00, rom_ce_q};
    issue_d  = (state_q == FETCH) && !icol_q[6] && (occ_d < 3'd2);
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    if (pop)
      buf0_d = (cnt_q == 2'd2) ? buf1_q : rom_dout;
    else if (cnt_q == 2'd0)
      buf0_d = rom_dout;
    if (!pop && (cnt_q == 2'd1))
      buf1_d = rom_dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= 5'd0;
      icol_q   <= 7'd0;
      ocol_q   <= 6'd0;
      cnt_q    <= 2'd0;
      lnd_q    <= 1'b0;
      buf0_q   <= 8'd0;
      buf1_q   <= 8'd0;
      rom_ce_q <= 1'b0;
      rom_ad_q <= 11'd0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q   <= 1'b0;
          rom_ce_q <= 1'b0;
          lnd_q    <= 1'b0;
          if (req) begin
            state_q  <= FETCH;
            row_q    <= req_row;
            rom_ce_q <= 1'b1;
            rom_ad_q <= {req_row, 6'd0};
            icol_q   <= 7'd1;
            ocol_q   <= 6'd0;
            cnt_q    <= 2'd0;
          end
        end
        FETCH: begin
          cnt_q    <= cnt_d;
          lnd_q    <= rom_ce_q;
          buf0_q   <= buf0_d;
          buf1_q   <= buf1_d;
          rom_ce_q <= issue_d;
          done_q   <= last_pop;
          if (issue_d) begin
            rom_ad_q <= {row_q, icol_q[5:0]};
            icol_q   <= icol_q + 7'd1;
          end
          if (pop)
            ocol_q <= ocol_q + 6'd1;
          if (last_pop)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = (state_q == FETCH);
  assign done    = done_q;
  assign rom_ce  = rom_ce_q;
  assign rom_oce = rom_ce_q;
  assign rom_ad  = rom_ad_q;
  assign ch_code = ch_valid ? head : 8'd0;
  assign ch_col  = ocol_q;
  assign ch_last = ch_valid & (ocol_q == 6'd63);

endmodule

// File: tb/tb_text_line_fetch.sv
// Random-backpressure bench for text_line_fetch: ROM model, expected-stream queue
// filled at request time, and a negedge monitor that pops and compares each handshake.
module tb_text_line_fetch;

  logic        clk = 1'b0;
  logic        reset, req, busy, done, rom_ce, rom_oce, ch_valid, ch_ready, ch_last;
  logic [4:0]  req_row;
  logic [10:0] rom_ad;
  logic [7:0]  rom_dout, ch_code;
  logic [5:0]  ch_col;

  always #5 clk = ~clk;

  text_line_fetch dut (
    .clk(clk), .reset(reset), .req(req), .req_row(req_row), .busy(busy), .done(done),
    .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_dout(rom_dout),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_code(ch_code), .ch_col(ch_col),
    .ch_last(ch_last)
  );

  logic [7:0] mem [0:2047];
  always @(posedge clk) if (rom_ce) rom_dout <= mem[rom_ad];

  typedef struct packed {logic [7:0] code; logic [5:0] col; logic last;} exp_t;
  exp_t sbq[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0]  exp_row = 5'd0;
  int          exp_icol = 0;
  logic [10:0] last_ad = 11'd0, max_ad = 11'd0;
  int          iss = 0, pops = 0, hs_cnt = 0, n_done = 0;
  int          req_cyc = 0, first_hs_cyc = 0;
  logic        done_exp = 1'b0, prev_stall = 1'b0, rnd_mode = 1'b0;
  logic [7:0]  prev_code, rx [0:63];
  logic [5:0]  prev_col;
  logic        prev_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: scoreboard pops, address order, hold/stability, occupancy, done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      done_exp = 1'b0; prev_stall = 1'b0; iss = 0; pops = 0; last_ad = 11'd0;
    end else begin
      chk("rom_oce", rom_oce, rom_ce);
      chk("done", done, done_exp);
      done_exp = 1'b0;
      if (done) n_done++;
      if (rom_ce) begin
        chk("rom_ad", rom_ad, {exp_row, exp_icol[5:0]});
        chk("icol_range", exp_icol < 64, 1);
        exp_icol++;
        last_ad = rom_ad;
        iss++;
        if (rom_ad > max_ad) max_ad = rom_ad;
      end else
        chk("rom_ad_hold", rom_ad, last_ad);
      if (prev_stall) begin
        chk("stall_valid", ch_valid, 1);
        chk("stall_code", ch_code, prev_code);
        chk("stall_col", ch_col, prev_col);
        chk("stall_last", ch_last, prev_last);
      end
      if (ch_valid && ch_ready) begin
        pops++; hs_cnt++;
        rx[ch_col] = ch_code;
        if (ch_col == 6'd0) first_hs_cyc = cyc;
        if (sbq.size() == 0)
          chk("unexpected_char", sbq.size(), 1);
        else begin
          e = sbq.pop_front();
          chk("ch_code", ch_code, e.code);
          chk("ch_col", ch_col, e.col);
          chk("ch_last", ch_last, e.last);
          if (e.last) done_exp = 1'b1;
        end
      end
      chk("occupancy", (iss - pops) <= 2, 1);
      prev_stall = ch_valid && !ch_ready;
      prev_code = ch_code; prev_col = ch_col; prev_last = ch_last;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_mode) ch_ready = 1'($urandom_range(0, 1));
  end

  // Called just after a clock edge; holds req for one cycle.
  task automatic start_row(input logic [4:0] r);
    logic [10:0] a;
    req = 1'b1; req_row = r; req_cyc = cyc;
    exp_row = r; exp_icol = 0; hs_cnt = 0; max_ad = 11'd0;
    for (int c = 0; c < 64; c++) begin
      a = {r, 6'(c)};
      sbq.push_back({mem[a], 6'(c), c == 63});
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done) begin dc = cyc; break; end
    end
    if (dc < 0) chk("done_timeout", done, 1);
  endtask

  task automatic wait_hs(input int n);
    for (int i = 0; i < 400; i++) begin
      if (hs_cnt >= n) break;
      @(posedge clk); #1;
    end
    chk("hs_reach", hs_cnt, n);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk(nm, {busy, done, rom_ce, rom_oce, rom_ad, ch_valid, ch_code, ch_col, ch_last}, 0);
  endtask

  initial begin
    int dc;
    reset = 1'b1; req = 1'b0; req_row = 5'd0; ch_ready = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'h2B; mem[1] = 8'h23; mem[2] = 8'h92; mem[11'h100] = 8'h2A;
    mem[11'h140] = 8'hF6; mem[11'h17F] = 8'hF6; mem[11'h7FF] = 8'hF6;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset_state");
    @(posedge clk); #1;

    // Row 0, ready always high: latency and known codes.
    ch_ready = 1'b1;
    start_row(5'd0); wait_done(dc);
    chk("r0_first_lat", first_hs_cyc - req_cyc, 2);
    chk("r0_done_lat", dc - req_cyc, 66);
    chk("r0_count", hs_cnt, 64);
    chk("r0_col0", rx[0], 8'h2B);
    chk("r0_col1", rx[1], 8'h23);
    chk("r0_col2", rx[2], 8'h92);

    // Rows 4 then 5, second request in the done cycle.
    start_row(5'd4); wait_done(dc);
    chk("r4_done_lat", dc - req_cyc, 66);
    chk("r4_col0", rx[0], 8'h2A);
    start_row(5'd5); wait_done(dc);
    chk("r5_first_lat", first_hs_cyc - req_cyc, 2);
    chk("r5_done_lat", dc - req_cyc, 66);
    chk("r5_col0", rx[0], 8'hF6);
    chk("r5_col63", rx[63], 8'hF6);

    // Row 31: top of the address space.
    start_row(5'd31); wait_done(dc);
    chk("r31_max_ad", max_ad, 11'h7FF);
    chk("r31_col63", rx[63], 8'hF6);
    chk("r31_done_lat", dc - req_cyc, 66);

    // Row 0 under random backpressure.
    rnd_mode = 1'b1;
    start_row(5'd0); wait_done(dc);
    rnd_mode = 1'b0; ch_ready = 1'b1;
    chk("rnd_count", hs_cnt, 64);
    for (int c = 0; c < 64; c++) chk("rnd_stream", rx[c], mem[c]);

    // Request pulsed mid-fetch must be ignored.
    start_row(5'd7);
    wait_hs(10);
    req = 1'b1; req_row = 5'd9;
    @(posedge clk); #1;
    req = 1'b0;
    wait_done(dc);
    chk("ign_count", hs_cnt, 64);
    chk("ign_done_lat", dc - req_cyc, 66);

    // Reset mid-fetch while stalled at column 30.
    start_row(5'd3);
    wait_hs(30);
    ch_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; sbq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("mid_reset");
    repeat (5) @(posedge clk);
    #1 ch_ready = 1'b1;
    start_row(5'd2); wait_done(dc);
    chk("r2_first_lat", first_hs_cyc - req_cyc, 2);
    chk("r2_count", hs_cnt, 64);
    chk("r2_done_lat", dc - req_cyc, 66);

    repeat (4) @(posedge clk);
    chk("sb_drained", sbq.size(), 0);
    chk("done_count", n_done, 7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
